// File: rtl/can_pkg.sv
// Shared CAN definitions: bus levels, standard fixed-field lengths and
// the state encoding of the fixed-field transmitter.
package can_pkg;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  localparam int unsigned SOF_LEN  = 1;
  localparam int unsigned EOF_LEN  = 7;
  localparam int unsigned IFS_LEN  = 3;
  localparam int unsigned FLAG_LEN = 6;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SYNC_WAIT = 2'd1,
    ST_SEND      = 2'd2,
    ST_DONE      = 2'd3
  } field_tx_state_t;

endpackage

// File: rtl/can_field_tx.sv
// Fixed-level CAN field transmitter (SOF, EOF, IFS, delimiters, flags):
// drives a run of identical bits, one per sample point, with optional readback check.
module can_field_tx
  import can_pkg::*;
#(
  parameter int MAX_LEN       = 11,
  parameter int LEN_W         = $clog2(MAX_LEN + 1),
  parameter bit STOP_ON_ERROR = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic [LEN_W-1:0] field_len,
  input  logic             field_level,
  input  logic             wait_hard_sync,
  input  logic             apply_hard_sync,
  input  logic             sample_point,
  input  logic             rx_bit,
  input  logic             check_enable,
  input  logic             abort,
  output logic             tx_bit,
  output logic             field_active,
  output logic             field_done,
  output logic             bit_error,
  output logic [LEN_W-1:0] bit_count
);

  field_tx_state_t  state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             level_q, level_d;
  logic             wait_q, wait_d;
  logic [LEN_W-1:0] bit_count_q, bit_count_d;
  logic             tx_bit_q, tx_bit_d;
  logic             field_active_q, field_active_d;
  logic             field_done_q, field_done_d;
  logic             bit_error_q, bit_error_d;
  logic             mismatch;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned (no latches).
    state_d     = state_q;
    len_d       = len_q;
    level_d     = level_q;
    wait_d      = wait_q;
    bit_count_d = bit_count_q;
    bit_error_d = 1'b0;
    mismatch    = check_enable && (rx_bit != level_q);

    if (!enable) begin
      state_d = ST_IDLE;
      len_d   = '0;
      level_d = RECESSIVE;
      wait_d  = 1'b0;
    end else if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && (field_len != '0)) begin
            len_d   = (field_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : field_len;
            level_d = field_level;
            wait_d  = wait_hard_sync;
            state_d = wait_hard_sync ? ST_SYNC_WAIT : ST_SEND;
          end
        end
        ST_SYNC_WAIT: begin
          if (apply_hard_sync || !wait_q) state_d = ST_SEND;
        end
        ST_SEND: begin
          if (sample_point) begin
            bit_count_d = bit_count_q + LEN_W'(1);
            bit_error_d = mismatch;
            if (mismatch && STOP_ON_ERROR) state_d = ST_IDLE;
            else if (bit_count_q == len_q - LEN_W'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // Counter is zero throughout IDLE and on the first cycle of SEND.
    if (state_d == ST_IDLE || (state_d == ST_SEND && state_q != ST_SEND)) bit_count_d = '0;

    tx_bit_d       = (state_d == ST_SEND) ? level_d : RECESSIVE;
    field_active_d = (state_d == ST_SEND);
    field_done_d   = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      level_q        <= RECESSIVE;
      wait_q         <= 1'b0;
      bit_count_q    <= '0;
      tx_bit_q       <= RECESSIVE;
      field_active_q <= 1'b0;
      field_done_q   <= 1'b0;
      bit_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      level_q        <= level_d;
      wait_q         <= wait_d;
      bit_count_q    <= bit_count_d;
      tx_bit_q       <= tx_bit_d;
      field_active_q <= field_active_d;
      field_done_q   <= field_done_d;
      bit_error_q    <= bit_error_d;
    end
  end

  assign tx_bit       = tx_bit_q;
  assign field_active = field_active_q;
  assign field_done   = field_done_q;
  assign bit_error    = bit_error_q;
  assign bit_count    = bit_count_q;

endmodule

// File: tb/tb_can_field_tx.sv
// Directed bench for can_field_tx: expected done/error pulses are queued by the
// stimulus and checked by a separate monitor; level outputs are checked inline.
module tb_can_field_tx;
  import can_pkg::*;

  localparam int LEN_W = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] field_len = '0;
  logic             field_level = 1'b1;
  logic             wait_hard_sync = 1'b0;
  logic             apply_hard_sync = 1'b0;
  logic             sample_point = 1'b0;
  logic             rx_bit = 1'b1;
  logic             check_enable = 1'b0;
  logic             abort = 1'b0;
  logic             tx_bit;
  logic             field_active;
  logic             field_done;
  logic             bit_error;
  logic [LEN_W-1:0] bit_count;

  can_field_tx #(.MAX_LEN(11), .LEN_W(LEN_W), .STOP_ON_ERROR(1'b1)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .start           (start),
    .field_len       (field_len),
    .field_level     (field_level),
    .wait_hard_sync  (wait_hard_sync),
    .apply_hard_sync (apply_hard_sync),
    .sample_point    (sample_point),
    .rx_bit          (rx_bit),
    .check_enable    (check_enable),
    .abort           (abort),
    .tx_bit          (tx_bit),
    .field_active    (field_active),
    .field_done      (field_done),
    .bit_error       (bit_error),
    .bit_count       (bit_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic             done;
    logic             err;
    logic [LEN_W-1:0] count;
  } exp_t;

  exp_t sb_q[$];
  exp_t ev;
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    sample_point = 1'b1;
    tick();
    sample_point = 1'b0;
  endtask

  task automatic launch(input logic [LEN_W-1:0] len, input logic level, input logic wsync);
    start          = 1'b1;
    field_len      = len;
    field_level    = level;
    wait_hard_sync = wsync;
    tick();
    start          = 1'b0;
    wait_hard_sync = 1'b0;
  endtask

  task automatic expect_event(input logic done, input logic err, input logic [LEN_W-1:0] count);
    exp_t e;
    e.done  = done;
    e.err   = err;
    e.count = count;
    sb_q.push_back(e);
  endtask

  // Monitor: every done/error pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset_n && (field_done || bit_error)) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_event: got done=%0b err=%0b expected no event (t=%0t)",
                 field_done, bit_error, $time);
      end else begin
        ev = sb_q.pop_front();
        check("ev_done", 32'(field_done), 32'(ev.done));
        check("ev_err", 32'(bit_error), 32'(ev.err));
        check("ev_count", 32'(bit_count), 32'(ev.count));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    check("rst_tx", 32'(tx_bit), 32'd1);
    check("rst_active", 32'(field_active), 32'd0);
    check("rst_done", 32'(field_done), 32'd0);
    check("rst_err", 32'(bit_error), 32'd0);
    check("rst_count", 32'(bit_count), 32'd0);
    reset_n = 1'b1;
    tick();

    // Hard sync outside SYNC_WAIT does nothing
    apply_hard_sync = 1'b1;
    tick();
    apply_hard_sync = 1'b0;
    check("idle_hsync_active", 32'(field_active), 32'd0);

    // SOF with hard-sync wait
    launch(LEN_W'(SOF_LEN), DOMINANT, 1'b1);
    check("sof_wait_active", 32'(field_active), 32'd0);
    check("sof_wait_tx", 32'(tx_bit), 32'd1);
    sample();
    tick();
    check("sof_wait_ignores_sp", 32'(field_active), 32'd0);
    apply_hard_sync = 1'b1;
    tick();
    apply_hard_sync = 1'b0;
    check("sof_send_active", 32'(field_active), 32'd1);
    check("sof_send_tx", 32'(tx_bit), 32'd0);
    tick();
    check("sof_hold_tx", 32'(tx_bit), 32'd0);
    expect_event(1'b1, 1'b0, LEN_W'(1));
    sample();
    check("sof_done_tx", 32'(tx_bit), 32'd1);
    check("sof_done_pulse", 32'(field_done), 32'd1);
    tick();
    check("sof_after_done", 32'(field_done), 32'd0);
    check("sof_after_tx", 32'(tx_bit), 32'd1);

    // EOF: 7 recessive bits, with a start pulse mid-field that must be ignored
    launch(LEN_W'(EOF_LEN), RECESSIVE, 1'b0);
    for (int i = 0; i < EOF_LEN; i++) begin
      check("eof_count", 32'(bit_count), 32'(i));
      check("eof_active", 32'(field_active), 32'd1);
      if (i == 3) begin
        start     = 1'b1;
        field_len = LEN_W'(2);
      end
      if (i == EOF_LEN - 1) expect_event(1'b1, 1'b0, LEN_W'(EOF_LEN));
      sample();
      start = 1'b0;
      if (i < EOF_LEN - 1) tick();
    end
    check("eof_done_active", 32'(field_active), 32'd0);
    check("eof_done_count", 32'(bit_count), 32'(EOF_LEN));
    tick();
    check("eof_idle_count", 32'(bit_count), 32'd0);

    // Error flag aborted by readback mismatch on 3rd sample point
    check_enable = 1'b1;
    rx_bit       = 1'b0;
    launch(LEN_W'(FLAG_LEN), DOMINANT, 1'b0);
    sample();
    sample();
    check("flag_count2", 32'(bit_count), 32'd2);
    rx_bit = 1'b1;
    expect_event(1'b0, 1'b1, LEN_W'(0));
    sample();
    check("flag_err_active", 32'(field_active), 32'd0);
    check("flag_err_tx", 32'(tx_bit), 32'd1);
    check_enable = 1'b0;
    tick();
    tick();
    check("flag_err_idle", 32'(field_active), 32'd0);

    // Abort coincident with final sample point of a 3-bit field
    launch(LEN_W'(IFS_LEN), DOMINANT, 1'b0);
    sample();
    sample();
    abort = 1'b1;
    sample();
    abort = 1'b0;
    check("abort_active", 32'(field_active), 32'd0);
    check("abort_tx", 32'(tx_bit), 32'd1);
    check("abort_done", 32'(field_done), 32'd0);
    tick();

    // Zero-length start is ignored
    launch(LEN_W'(0), DOMINANT, 1'b0);
    check("len0_active", 32'(field_active), 32'd0);
    tick();
    check("len0_tx", 32'(tx_bit), 32'd1);

    // Overlong request is clamped to MAX_LEN = 11
    launch(LEN_W'(15), DOMINANT, 1'b0);
    for (int i = 0; i < 11; i++) begin
      check("clamp_active", 32'(field_active), 32'd1);
      if (i == 10) expect_event(1'b1, 1'b0, LEN_W'(11));
      sample();
    end
    check("clamp_done_count", 32'(bit_count), 32'd11);
    check("clamp_done_active", 32'(field_active), 32'd0);
    tick();

    // Asynchronous reset mid-SEND
    launch(LEN_W'(EOF_LEN), DOMINANT, 1'b0);
    sample();
    sample();
    reset_n = 1'b0;
    #1;
    check("areset_tx", 32'(tx_bit), 32'd1);
    check("areset_active", 32'(field_active), 32'd0);
    check("areset_count", 32'(bit_count), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Synchronous clear via enable mid-field
    launch(LEN_W'(5), DOMINANT, 1'b0);
    sample();
    check("en_send_tx", 32'(tx_bit), 32'd0);
    enable = 1'b0;
    tick();
    check("en_low_active", 32'(field_active), 32'd0);
    check("en_low_tx", 32'(tx_bit), 32'd1);
    check("en_low_count", 32'(bit_count), 32'd0);
    enable = 1'b1;
    tick();
    tick();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/can_field_tx.md
# can_field_tx

Parametrised fixed-form field transmitter for the CAN data-frame path. It generalises start-of-frame generation to any fixed-level field: SOF, EOF, intermission, delimiters, or a dominant error/overload flag. A field is a run of 1..MAX_LEN identical bits, driven one bit per sample point, with optional hard-sync wait and optional bit-error readback. It sits between the frame sequencer, which requests fields, and the bit-timing unit, which supplies hard sync and sample points.

## Interface
Parameters:
- MAX_LEN, 11, longest field in bits (EOF 7, intermission 3, flags 6, SOF 1)
- LEN_W, $clog2(MAX_LEN+1), width of field_len and bit_count
- STOP_ON_ERROR, 1, 1 = abort field on bit error; 0 = flag error and continue

Ports:
- clock  input  1  single clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  synchronous clear to IDLE when low
- start  input  1  field request, sampled in IDLE only
- field_len  input  LEN_W  bit count, latched on accepted start
- field_level  input  1  bit value, latched on accepted start (0 dominant, 1 recessive)
- wait_hard_sync  input  1  latched on start; 1 = wait for apply_hard_sync before sending
- apply_hard_sync  input  1  hard-sync pulse from bit timing
- sample_point  input  1  one-cycle sample strobe from bit timing
- rx_bit  input  1  bus readback
- check_enable  input  1  compare rx_bit against the transmitted level at sample points
- abort  input  1  cancel the field immediately
- tx_bit  output  1  bit driven to the bus; recessive (1) when not sending
- field_active  output  1  high while in SEND
- field_done  output  1  one-cycle pulse on normal completion
- bit_error  output  1  one-cycle pulse on readback mismatch
- bit_count  output  LEN_W  bits completed in the current field

## Operation
- States: IDLE, SYNC_WAIT, SEND, DONE.
- IDLE → start with field_len ≠ 0 → SYNC_WAIT if wait_hard_sync, otherwise SEND.
  - On this transition, latch field_len (clamped to MAX_LEN), field_level and wait_hard_sync.
  - start with field_len = 0 is ignored.
- SYNC_WAIT → apply_hard_sync → SEND.
- SEND, at each sample_point:
  - Increment bit_count.
  - When bit_count = len−1 → DONE.
- DONE → IDLE unconditionally, after one cycle.
- start outside IDLE is ignored; there is no queueing.
- Bit error: at a SEND sample_point with check_enable=1 and rx_bit ≠ latched level:
  - bit_error pulses.
  - If STOP_ON_ERROR=1 → IDLE, with no field_done.
  - If STOP_ON_ERROR=0 → counting continues normally.
- Output decode (registered, aligned with the state register, no extra lag):
  - tx_bit = latched level in SEND, else 1.
  - field_active = (state == SEND).
  - field_done = (state == DONE).
- bit_count clears to 0 on entry to SEND and in IDLE, and holds its value in DONE.

## Timing
- Reset (reset_n low, or enable low at the clock edge):
  - state IDLE, tx_bit 1, field_active 0, field_done 0, bit_error 0, bit_count 0.
  - Latched registers clear to len 0, level 1.
- Latency:
  - start at edge N → SEND at N+1 (no wait) or SYNC_WAIT at N+1.
  - apply_hard_sync at edge M → SEND at M+1.
  - Final sample_point at edge K → DONE at K+1 (field_done high one cycle) → IDLE at K+2.
- bit_error is registered and high in the cycle after the offending sample_point.
- Abort: from any state → IDLE at the next edge; tx_bit is 1 the cycle after.
  - Abort takes priority over a simultaneous final sample_point: no field_done.
  - Abort takes priority over a simultaneous bit error: no bit_error.
- apply_hard_sync outside SYNC_WAIT is ignored.
- sample_point outside SEND is ignored.
- Simultaneous bit error and final sample_point:
  - STOP_ON_ERROR=1 → IDLE with bit_error, no field_done.
  - STOP_ON_ERROR=0 → DONE with bit_error.
- Reset or enable low mid-field → IDLE next edge; no done or error pulse.

## Structure
- Shared package can_pkg:
  - field_tx_state_t enum (2 bits).
  - Constants DOMINANT=1'b0, RECESSIVE=1'b1.
  - Field-length constants SOF_LEN=1, EOF_LEN=7, IFS_LEN=3, FLAG_LEN=6.
- Single module; no sub-module. Implement the counter inline.

## Test plan
- SOF: start, len 1, level 0, wait_hard_sync=1 → remains in SYNC_WAIT until apply_hard_sync; tx_bit 0 for exactly one sample period; field_done pulses once; tx_bit 1 afterwards.
- EOF: len 7, level 1, no wait → field_active high across 7 sample points; bit_count steps 0..6; field_done the cycle after the 7th sample point.
- Error flag with STOP_ON_ERROR=1: len 6, level 0, check_enable=1, rx_bit=1 at the 3rd sample point → bit_error pulse, return to IDLE, no field_done, tx_bit 1.
- Abort coincident with the final sample_point of a len-3 field → IDLE next edge, no field_done.
- Length edges:
  - field_len=0 → start ignored; state stays IDLE.
  - field_len=15 with MAX_LEN=11 → exactly 11 bits sent.
  - start pulsed during SEND → ignored.
- reset_n asserted asynchronously mid-SEND → all outputs at reset values immediately; enable low mid-field → IDLE at next edge.
